lab2_bcd_scan_counter: RTL and testbench

LAB2_BCD_SCAN_COUNTER -- requirements
Module: lab2_bcd_scan_counter

---
 rtl/lab2_bcd_scan_counter.sv | 134 +++++++++++++
 tb/tb_lab2_bcd_scan_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lab2_bcd_scan_counter.sv
// rtl/lab2_bcd_scan_counter.sv - 4-digit BCD up/down counter with multiplexed 7-segment scan outputs
// Optional leading-zero blanking: define LAB2_BLANK_LEADING_ZERO_EN.

module lab2_bcd_scan_counter #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  bcd_out,
  output logic [3:0]  dig_sel
);

  // Keep the divider at least one bit wide so SCAN_DIV=1 still elaborates.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  logic [15:0] load_sat;
  logic [15:0] count_inc;
  logic [15:0] count_dec;
  logic        inc_carry;
  logic        dec_borrow;
  logic [3:0]  digit;
  logic [3:0]  digit_zero;

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < 4; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Ripple carry: a digit only moves while everything below it rolled over.
  always_comb begin
    count_inc = count;
    inc_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_dec  = count;
    dec_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dec_borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_sat;
      wrap  <= 1'b0;
    end else if (en) begin
      if (up) begin
        count <= count_inc;
        wrap  <= inc_carry;
      end else begin
        count <= count_dec;
        wrap  <= dec_borrow;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Scan timing free-runs; counter activity never touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    dig_sel = 4'b0001 << idx;
    digit   = count[{idx, 2'b00} +: 4];
    for (int i = 0; i < 4; i++) begin
      digit_zero[i] = (count[4*i +: 4] == 4'd0);
    end
  end

`ifdef LAB2_BLANK_LEADING_ZERO_EN
  logic blank;

  always_comb begin
    case (idx)
      2'd3:    blank = digit_zero[3];
      2'd2:    blank = digit_zero[3] & digit_zero[2];
      2'd1:    blank = digit_zero[3] & digit_zero[2] & digit_zero[1];
      default: blank = 1'b0;
    endcase
    bcd_out = blank ? 4'b1111 : digit;
  end
`else
  logic unused_zero;

  always_comb begin
    unused_zero = ^digit_zero;
    bcd_out     = digit;
  end
`endif

endmodule

// File: tb/tb_lab2_bcd_scan_counter.sv
// tb/tb_lab2_bcd_scan_counter.sv - directed scoreboard bench for lab2_bcd_scan_counter

module tb_lab2_bcd_scan_counter;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel;

  lab2_bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .bcd_out  (bcd_out),
    .dig_sel  (dig_sel)
  );

  always #5 clk = ~clk;

  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  typedef struct {
    logic [15:0] c;
    logic        w;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_digit(input logic [15:0] c, input int i);
    logic [3:0] d;
    d = c[4*i +: 4];
`ifdef LAB2_BLANK_LEADING_ZERO_EN
    if (i > 0 && (c >> (4*i)) == 16'h0000) d = 4'hF;
`endif
    return d;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check_scan(input string tag, input logic [15:0] c);
    int i;
    i = (edges / SCAN_DIV) % 4;
    chk({tag, ".dig_sel"}, {12'h000, dig_sel}, 16'(1 << i));
    chk({tag, ".bcd_out"}, {12'h000, bcd_out}, {12'h000, exp_digit(c, i)});
  endtask

  task automatic step(input logic ld, input logic [15:0] val, input logic e, input logic u,
                      input logic [15:0] exp_c, input logic exp_w, input string tag);
    exp_t x;
    load     = ld;
    load_val = val;
    en       = e;
    up       = u;
    x.c = exp_c;
    x.w = exp_w;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 16'h0001, 16'h0000);
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".count"}, count, x.c);
      chk({x.tag, ".wrap"}, {15'h0, wrap}, {15'h0, x.w});
      check_scan(x.tag, x.c);
    end
  endtask

  initial begin
    int v;
    // Inputs active while reset held: nothing may move.
    load = 1'b1; load_val = 16'h1234; en = 1'b1; up = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.count", count, 16'h0000);
    chk("rst.wrap", {15'h0, wrap}, 16'h0000);
    chk("rst.dig_sel", {12'h0, dig_sel}, 16'h0001);
    chk("rst.bcd_out", {12'h0, bcd_out}, 16'h0000);
    load = 1'b0; en = 1'b0; up = 1'b0;
    rst_n = 1'b1;

    step(1'b1, 16'h3A7F, 1'b0, 1'b0, 16'h3979, 1'b0, "load_sat");

    step(1'b1, 16'h9998, 1'b0, 1'b0, 16'h9998, 1'b0, "ld9998");
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, "inc9999");
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, "inc_wrap");
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, "inc0001");

    step(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, "ld0001");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "dec0000");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1, "dec_wrap");
    step(1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, "ld1000");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0999, 1'b0, "dec_borrow");
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0999, 1'b0, "hold");

    step(1'b1, 16'h0500, 1'b1, 1'b1, 16'h0500, 1'b0, "load_wins");
    step(1'b1, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b0, "load_no_wrap");

    step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, "ld1234");
    repeat (16) step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, "scan1234");

    step(1'b1, 16'h0042, 1'b0, 1'b0, 16'h0042, 1'b0, "ld0042");
    repeat (16) step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0042, 1'b0, "scan0042");
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "ld0000");
    repeat (16) step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "scan0000");

    v = 9995;
    step(1'b1, to_bcd(v), 1'b0, 1'b0, to_bcd(v), 1'b0, "ld_model");
    for (int k = 0; k < 10; k++) begin
      v = (v + 1) % 10000;
      step(1'b0, 16'h0000, 1'b1, 1'b1, to_bcd(v), v == 0, "model_up");
    end
    for (int k = 0; k < 12; k++) begin
      v = (v + 9999) % 10000;
      step(1'b0, 16'h0000, 1'b1, 1'b0, to_bcd(v), v == 9999, "model_dn");
    end

    // Asynchronous reset in the middle of a high period while counting.
    step(1'b1, 16'h0457, 1'b1, 1'b1, 16'h0457, 1'b0, "ld0457");
    en = 1'b1; up = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async.count", count, 16'h0000);
    chk("async.wrap", {15'h0, wrap}, 16'h0000);
    chk("async.dig_sel", {12'h0, dig_sel}, 16'h0001);
    chk("async.bcd_out", {12'h0, bcd_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, "post_reset_inc");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "post_reset_dec");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
